// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg: shared widths and scheduler state encoding for the AES decrypt path |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int AES_KEY_W   = 128;
  // Wide enough for the largest legal TIMEOUT (1023) and KEY_WAIT (255).
  localparam int SCHED_CNT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYLD   = 3'd1,
    ST_KEYWAIT = 3'd2,
    ST_LOAD    = 3'd3,
    ST_RUN     = 3'd4,
    ST_HOLD    = 3'd5
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_sched_cnt.sv
// +----------------------------------------------------------------------------+
// | aes_sched_cnt: loadable saturating down-counter with a zero flag            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sched_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/aes_inv_sched.sv
// +----------------------------------------------------------------------------+
// | aes_inv_sched: job scheduler with key cache for an inverse-cipher AES core  |
// | Optional RUN watchdog enabled by AES_INV_SCHED_TIMEOUT_EN.  Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_sched
  import aes_pkg::*;
#(
  parameter int KEY_WAIT = 12,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_KEY_W-1:0] in_key,
  input  logic [AES_BLK_W-1:0] in_text,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_text,
  output logic                 core_kld,
  output logic                 core_ld,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out,
  output logic                 timeout
);

  localparam logic [SCHED_CNT_W-1:0] KW_LOAD = SCHED_CNT_W'(KEY_WAIT - 1);
  localparam logic [SCHED_CNT_W-1:0] WD_LOAD = SCHED_CNT_W'(TIMEOUT - 1);

  sched_state_t state;
  sched_state_t state_nx;

  logic                   key_vld;
  logic [AES_KEY_W-1:0]   cache_key;
  logic                   accept;
  logic                   hit;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic [SCHED_CNT_W-1:0] cnt_load_val;
  logic                   cnt_zero;
  logic                   wd_expire;

  assign accept = (state == ST_IDLE) && in_valid;
  assign hit    = key_vld && (in_key == cache_key);

`ifdef AES_INV_SCHED_TIMEOUT_EN
  assign wd_expire = (state == ST_RUN) && !core_done && cnt_zero;
`else
  assign wd_expire = 1'b0;
`endif

  // One counter serves both phases: loaded in KEYLD for the key settle time,
  // reloaded in LOAD for the RUN watchdog. The two phases never overlap.
  assign cnt_load     = (state == ST_KEYLD) || (state == ST_LOAD);
  assign cnt_dec      = (state == ST_KEYWAIT) || (state == ST_RUN);
  assign cnt_load_val = (state == ST_KEYLD) ? KW_LOAD : WD_LOAD;

  aes_sched_cnt #(
    .W (SCHED_CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = hit ? ST_LOAD : ST_KEYLD;
      ST_KEYLD:   state_nx = ST_KEYWAIT;
      ST_KEYWAIT: if (cnt_zero) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_RUN;
      ST_RUN: begin
        if (core_done) begin
          state_nx = ST_HOLD;
        end else if (wd_expire) begin
          state_nx = ST_IDLE;
        end
      end
      ST_HOLD:    if (out_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign core_kld  = (state == ST_KEYLD);
  assign core_ld   = (state == ST_LOAD);
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_vld      <= 1'b0;
      cache_key    <= '0;
      core_key     <= '0;
      core_text_in <= '0;
      out_text     <= '0;
      timeout      <= 1'b0;
    end else begin
      timeout <= wd_expire;
      if (accept) begin
        core_key     <= in_key;
        core_text_in <= in_text;
        if (!hit) begin
          cache_key <= in_key;
          key_vld   <= 1'b0;
        end
      end
      // The cached key only becomes trustworthy once the core has had its
      // full settle time; an aborted job leaves the core state unknown.
      if ((state == ST_KEYWAIT) && cnt_zero) begin
        key_vld <= 1'b1;
      end
      if (wd_expire) begin
        key_vld <= 1'b0;
      end
      if ((state == ST_RUN) && core_done) begin
        out_text <= core_text_out;
      end
    end
  end

endmodule

`default_nettype wire
